// File: rtl/usb_pkg.sv
// Shared USB device constants: handshake codes, IN scheduler state encodings
// and endpoint numbers.
package usb_pkg;

  localparam logic [1:0] HS_ACK   = 2'b00;
  localparam logic [1:0] HS_NONE  = 2'b01;
  localparam logic [1:0] HS_NAK   = 2'b10;
  localparam logic [1:0] HS_STALL = 2'b11;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LOAD     = 2'd1;
  localparam logic [1:0] ST_SEND     = 2'd2;
  localparam logic [1:0] ST_WAIT_ACK = 2'd3;

  localparam logic [3:0] EP_CTRL = 4'd0;
  localparam logic [3:0] EP_IN1  = 4'd1;

endpackage

// File: rtl/usb_in_toggle.sv
// DATA0/DATA1 toggle bits for EP0 and EP1: SETUP forces EP0 to DATA1,
// an ACKed packet flips the selected endpoint's bit.
module usb_in_toggle (
  input  logic       clk,
  input  logic       usb_rst,
  input  logic       i_set0,
  input  logic       i_flip,
  input  logic       i_flip_sel,
  output logic [1:0] o_toggle
);

  logic [1:0] w_set;
  logic [1:0] w_flip;
  logic [1:0] r_toggle;

  assign w_set  = {1'b0, i_set0};
  assign w_flip = {i_flip & i_flip_sel, i_flip & ~i_flip_sel};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bit
      always_ff @(posedge clk) begin
        if (usb_rst) begin
          r_toggle[gi] <= 1'b0;
        end else if (w_set[gi]) begin
          r_toggle[gi] <= 1'b1;
        end else if (w_flip[gi]) begin
          r_toggle[gi] <= ~r_toggle[gi];
        end
      end
    end
  endgenerate

  assign o_toggle = r_toggle;

endmodule

// File: rtl/usb_in_scheduler.sv
// IN packet scheduler: streams one packet from EP0 or EP1 into the send queue
// per IN token, or answers NAK/STALL, and tracks DATA0/DATA1 per endpoint.
module usb_in_scheduler
  import usb_pkg::*;
#(
  parameter int EP0_MAX = 8,
  parameter int EP1_MAX = 64
) (
  input  logic       clk,
  input  logic       usb_rst,
  input  logic       in_token,
  input  logic [3:0] token_ep,
  input  logic       setup_token,
  input  logic       ack_received,
  input  logic       ack_timeout,
  input  logic       tx_done,
  input  logic       usb_send_queue_empty,
  output logic       usb_send_queue_w_en,
  output logic [7:0] usb_send_queue_data_in,
  output logic       tx_go,
  output logic       tx_data1,
  output logic       hs_valid,
  output logic [1:0] handshake,
  input  logic       ep0_valid,
  input  logic       ep0_zlp,
  input  logic [7:0] ep0_data,
  input  logic       ep0_last,
  input  logic       ep0_stall,
  output logic       ep0_ready,
  output logic       ep0_done,
  output logic       ep0_retry,
  input  logic       ep1_valid,
  input  logic       ep1_zlp,
  input  logic [7:0] ep1_data,
  input  logic       ep1_last,
  input  logic       ep1_stall,
  output logic       ep1_ready,
  output logic       ep1_done,
  output logic       ep1_retry
);

  localparam logic [6:0] MAX0 = 7'(EP0_MAX);
  localparam logic [6:0] MAX1 = 7'(EP1_MAX);

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       r_sel;
  logic       r_zlp;
  logic [6:0] r_count;
  logic       r_hs_valid;
  logic [1:0] r_handshake;
  logic [1:0] r_done;
  logic [1:0] r_retry;
  logic [1:0] w_toggle;

  logic       w_in_idle, w_tok_ok, w_t_stall, w_t_valid, w_t_zlp, w_accept;
  logic       w_src_valid, w_src_last;
  logic [7:0] w_src_data;
  logic [6:0] w_max;
  logic       w_abort, w_wr, w_load_end, w_flip;

  // tx_done is purely informational: the ACK/timeout pulses close the packet.
  logic       w_unused;
  assign w_unused = tx_done;

  assign w_in_idle = (r_state == ST_IDLE);
  assign w_tok_ok  = (token_ep == EP_CTRL) || (token_ep == EP_IN1);
  assign w_t_stall = token_ep[0] ? ep1_stall : ep0_stall;
  assign w_t_valid = token_ep[0] ? ep1_valid : ep0_valid;
  assign w_t_zlp   = token_ep[0] ? ep1_zlp   : ep0_zlp;
  assign w_accept  = in_token && w_in_idle && w_tok_ok && !w_t_stall
                     && w_t_valid && usb_send_queue_empty;

  assign w_src_valid = r_sel ? ep1_valid : ep0_valid;
  assign w_src_last  = r_sel ? ep1_last  : ep0_last;
  assign w_src_data  = r_sel ? ep1_data  : ep0_data;
  assign w_max       = r_sel ? MAX1 : MAX0;

  // A SETUP kills an EP0 transfer in flight; EP1 transfers are untouched.
  assign w_abort    = setup_token && !r_sel && !w_in_idle;
  assign w_wr       = (r_state == ST_LOAD) && !r_zlp && w_src_valid && !w_abort;
  // A ZLP spends one empty LOAD cycle so token-to-tx_go matches a one-byte packet.
  assign w_load_end = (r_state == ST_LOAD)
                      && (r_zlp || (w_wr && (w_src_last || (r_count + 7'd1) == w_max)));
  assign w_flip     = (r_state == ST_WAIT_ACK) && ack_received && !w_abort;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_state_next = ST_LOAD;
      ST_LOAD: if (w_load_end) w_state_next = ST_SEND;
      ST_SEND:                 w_state_next = ST_WAIT_ACK;
      default: if (ack_received || ack_timeout) w_state_next = ST_IDLE;
    endcase
    if (w_abort) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (usb_rst) begin
      r_state     <= ST_IDLE;
      r_sel       <= 1'b0;
      r_zlp       <= 1'b0;
      r_count     <= 7'd0;
      r_hs_valid  <= 1'b0;
      r_handshake <= HS_NONE;
      r_done      <= 2'b00;
      r_retry     <= 2'b00;
    end else begin
      r_state     <= w_state_next;
      r_hs_valid  <= 1'b0;
      r_handshake <= HS_NONE;
      r_done      <= 2'b00;
      r_retry     <= 2'b00;
      if (in_token && w_in_idle) begin
        if (!w_tok_ok || w_t_stall) begin
          r_hs_valid  <= 1'b1;
          r_handshake <= HS_STALL;
        end else if (!w_t_valid || !usb_send_queue_empty) begin
          r_hs_valid  <= 1'b1;
          r_handshake <= HS_NAK;
        end else begin
          r_sel   <= token_ep[0];
          r_count <= 7'd0;
          r_zlp   <= w_t_zlp;
        end
      end
      if (w_wr) r_count <= r_count + 7'd1;
      if ((r_state == ST_WAIT_ACK) && !w_abort) begin
        if (ack_received)     r_done[r_sel]  <= 1'b1;
        else if (ack_timeout) r_retry[r_sel] <= 1'b1;
      end
      if (w_abort) r_retry[0] <= 1'b1;
    end
  end

  usb_in_toggle u_toggle (
    .clk        (clk),
    .usb_rst    (usb_rst),
    .i_set0     (setup_token),
    .i_flip     (w_flip),
    .i_flip_sel (r_sel),
    .o_toggle   (w_toggle)
  );

  assign usb_send_queue_w_en    = w_wr;
  assign usb_send_queue_data_in = w_wr ? w_src_data : 8'h00;
  assign ep0_ready              = w_wr && !r_sel;
  assign ep1_ready              = w_wr && r_sel;
  assign tx_go                  = (r_state == ST_SEND) && !w_abort;
  assign tx_data1               = tx_go && w_toggle[r_sel];
  assign hs_valid               = r_hs_valid;
  assign handshake              = r_handshake;
  assign ep0_done               = r_done[0];
  assign ep1_done               = r_done[1];
  assign ep0_retry              = r_retry[0];
  assign ep1_retry              = r_retry[1];

endmodule

// File: tb/tb_usb_in_scheduler.sv
// Directed bench for usb_in_scheduler: byte streaming, truncation, PID toggling,
// NAK/STALL answers, ZLP, bus reset and ACK/timeout collisions.
module tb_usb_in_scheduler;
  import usb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       usb_rst = 1'b1, in_token = 1'b0, setup_token = 1'b0;
  logic [3:0] token_ep = 4'd0;
  logic       ack_received = 1'b0, ack_timeout = 1'b0, tx_done = 1'b0;
  logic       usb_send_queue_empty = 1'b1;
  logic       w_en, tx_go, tx_data1, hs_valid;
  logic [7:0] data_in;
  logic [1:0] handshake;
  logic       ep0_valid = 1'b0, ep0_zlp = 1'b0, ep0_last, ep0_stall = 1'b0;
  logic       ep1_valid = 1'b0, ep1_zlp = 1'b0, ep1_last, ep1_stall = 1'b0;
  logic [7:0] ep0_data, ep1_data;
  logic       ep0_ready, ep0_done, ep0_retry, ep1_ready, ep1_done, ep1_retry;

  logic [7:0] src_mem [2][16];
  int         src_len [2] = '{1, 1};
  int         src_ptr [2] = '{0, 0};

  assign ep0_data = src_mem[0][src_ptr[0][3:0]];
  assign ep1_data = src_mem[1][src_ptr[1][3:0]];
  assign ep0_last = (src_ptr[0] == src_len[0] - 1);
  assign ep1_last = (src_ptr[1] == src_len[1] - 1);

  usb_in_scheduler #(.EP0_MAX(8), .EP1_MAX(64)) dut (
    .clk(clk), .usb_rst(usb_rst), .in_token(in_token), .token_ep(token_ep),
    .setup_token(setup_token), .ack_received(ack_received), .ack_timeout(ack_timeout),
    .tx_done(tx_done), .usb_send_queue_empty(usb_send_queue_empty),
    .usb_send_queue_w_en(w_en), .usb_send_queue_data_in(data_in),
    .tx_go(tx_go), .tx_data1(tx_data1), .hs_valid(hs_valid), .handshake(handshake),
    .ep0_valid(ep0_valid), .ep0_zlp(ep0_zlp), .ep0_data(ep0_data), .ep0_last(ep0_last),
    .ep0_stall(ep0_stall), .ep0_ready(ep0_ready), .ep0_done(ep0_done), .ep0_retry(ep0_retry),
    .ep1_valid(ep1_valid), .ep1_zlp(ep1_zlp), .ep1_data(ep1_data), .ep1_last(ep1_last),
    .ep1_stall(ep1_stall), .ep1_ready(ep1_ready), .ep1_done(ep1_done), .ep1_retry(ep1_retry)
  );

  // Event recorder, sampled mid-cycle.
  int         cyc = 0, wr_cnt = 0, tx_cnt = 0, hs_cnt = 0;
  int         tok_cyc = 0, tx_cyc = 0, hs_cyc = 0;
  logic [7:0] wr_log [256];
  int         wr_cyc [256];
  logic       tx_d1 = 1'b0;
  logic [1:0] hs_code = 2'b01;
  int         done_cnt [2] = '{0, 0};
  int         retry_cnt [2] = '{0, 0};
  logic       rdy_seen [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    cyc <= cyc + 1;
    rdy_seen[0] <= ep0_ready;
    rdy_seen[1] <= ep1_ready;
    if (in_token) tok_cyc <= cyc;
    if (w_en) begin
      wr_log[wr_cnt[7:0]] <= data_in;
      wr_cyc[wr_cnt[7:0]] <= cyc;
      wr_cnt <= wr_cnt + 1;
    end
    if (tx_go) begin
      tx_cnt <= tx_cnt + 1;
      tx_d1  <= tx_data1;
      tx_cyc <= cyc;
    end
    if (hs_valid) begin
      hs_cnt  <= hs_cnt + 1;
      hs_code <= handshake;
      hs_cyc  <= cyc;
    end
    if (ep0_done)  done_cnt[0]  <= done_cnt[0] + 1;
    if (ep1_done)  done_cnt[1]  <= done_cnt[1] + 1;
    if (ep0_retry) retry_cnt[0] <= retry_cnt[0] + 1;
    if (ep1_retry) retry_cnt[1] <= retry_cnt[1] + 1;
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++)
      if (rdy_seen[n] && src_ptr[n] < 15) src_ptr[n]++;
  endtask

  task automatic load_src(input int n, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) src_mem[n][i] = base + 8'(i);
    src_len[n] = len;
    src_ptr[n] = 0;
  endtask

  task automatic token(input logic [3:0] ep);
    in_token = 1'b1;
    token_ep = ep;
    tick();
    in_token = 1'b0;
    token_ep = 4'd0;
  endtask

  task automatic wait_tx(input string tag);
    int t0 = tx_cnt;
    int k = 0;
    while (tx_cnt == t0 && k < 40) begin
      tick();
      k++;
    end
    check(tag, 32'(tx_cnt - t0), 1);
  endtask

  task automatic hs_in(input logic a, input logic t);
    ack_received = a;
    ack_timeout  = t;
    tick();
    ack_received = 1'b0;
    ack_timeout  = 1'b0;
    repeat (2) tick();
  endtask

  task automatic hs_token(input string tag, input logic [3:0] ep, input logic [1:0] code);
    token(ep);
    repeat (2) tick();
    check({tag, "_code"}, 32'(hs_code), 32'(code));
    check({tag, "_lat"}, 32'(hs_cyc - tok_cyc), 1);
  endtask

  int w0, d0, r0, h0, t0;

  initial begin
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < 16; i++) src_mem[n][i] = 8'h00;

    repeat (3) tick();
    #1;
    check("rst_strobes", {w_en, tx_go, hs_valid, tx_data1, ep0_ready, ep1_ready,
                          ep0_done, ep1_done, ep0_retry, ep1_retry}, 0);
    check("rst_handshake", 32'(handshake), 32'(HS_NONE));
    check("rst_data_in", 32'(data_in), 0);
    usb_rst = 1'b0;
    tick();

    // EP1: five bytes, DATA0, then ACK flips to DATA1
    load_src(1, 5, 8'h11);
    ep1_valid = 1'b1;
    w0 = wr_cnt;
    token(EP_IN1);
    wait_tx("t1_tx");
    check("t1_nwr", 32'(wr_cnt - w0), 5);
    for (int i = 0; i < 5; i++) check("t1_byte", 32'(wr_log[w0 + i]), 32'(8'h11 + i));
    check("t1_first_lat", 32'(wr_cyc[w0] - tok_cyc), 1);
    check("t1_tx_lat", 32'(tx_cyc - wr_cyc[w0 + 4]), 1);
    check("t1_pid", 32'(tx_d1), 0);
    d0 = done_cnt[1];
    hs_in(1'b1, 1'b0);
    check("t1_done", 32'(done_cnt[1] - d0), 1);
    load_src(1, 1, 8'h99);
    token(EP_IN1);
    wait_tx("t1b_tx");
    check("t1b_pid", 32'(tx_d1), 1);
    hs_in(1'b1, 1'b0);

    // EP0: 12 bytes offered, truncated at 8; timeout replays with same PID
    load_src(0, 12, 8'h40);
    ep0_valid = 1'b1;
    w0 = wr_cnt;
    token(EP_CTRL);
    wait_tx("t2_tx");
    check("t2_nwr", 32'(wr_cnt - w0), 8);
    check("t2_last_byte", 32'(wr_log[w0 + 7]), 32'h47);
    check("t2_pid", 32'(tx_d1), 0);
    r0 = retry_cnt[0];
    d0 = done_cnt[0];
    hs_in(1'b0, 1'b1);
    check("t2_retry", 32'(retry_cnt[0] - r0), 1);
    check("t2_no_done", 32'(done_cnt[0] - d0), 0);
    load_src(0, 12, 8'h40);
    w0 = wr_cnt;
    token(EP_CTRL);
    wait_tx("t2r_tx");
    check("t2r_nwr", 32'(wr_cnt - w0), 8);
    check("t2r_pid", 32'(tx_d1), 0);
    hs_in(1'b1, 1'b0);
    load_src(0, 1, 8'h60);
    token(EP_CTRL);
    wait_tx("t2n_tx");
    check("t2n_pid", 32'(tx_d1), 1);
    hs_in(1'b1, 1'b0);

    // SETUP forces EP0 to DATA1; after ACK the next packet is DATA0
    setup_token = 1'b1;
    tick();
    setup_token = 1'b0;
    load_src(0, 2, 8'h70);
    w0 = wr_cnt;
    token(EP_CTRL);
    wait_tx("t3_tx");
    check("t3_nwr", 32'(wr_cnt - w0), 2);
    check("t3_pid", 32'(tx_d1), 1);
    hs_in(1'b1, 1'b0);
    load_src(0, 1, 8'h80);
    token(EP_CTRL);
    wait_tx("t3b_tx");
    check("t3b_pid", 32'(tx_d1), 0);
    hs_in(1'b1, 1'b0);

    // NAK / STALL answers, no queue writes or transmissions
    w0 = wr_cnt;
    h0 = hs_cnt;
    t0 = tx_cnt;
    ep1_valid = 1'b0;
    hs_token("t4_nak_invalid", EP_IN1, HS_NAK);
    ep1_valid = 1'b1;
    ep1_stall = 1'b1;
    hs_token("t4_stall_ep1", EP_IN1, HS_STALL);
    ep1_stall = 1'b0;
    hs_token("t4_stall_ep3", 4'd3, HS_STALL);
    usb_send_queue_empty = 1'b0;
    hs_token("t4_nak_busy", EP_IN1, HS_NAK);
    usb_send_queue_empty = 1'b1;
    check("t4_hs_count", 32'(hs_cnt - h0), 4);
    check("t4_no_wr", 32'(wr_cnt - w0), 0);
    check("t4_no_tx", 32'(tx_cnt - t0), 0);

    // EP0 ZLP (toggle is DATA1 here), then bus reset while awaiting ACK
    ep0_zlp = 1'b1;
    w0 = wr_cnt;
    token(EP_CTRL);
    wait_tx("t5_tx");
    check("t5_no_wr", 32'(wr_cnt - w0), 0);
    check("t5_tx_lat", 32'(tx_cyc - tok_cyc), 2);
    check("t5_pid", 32'(tx_d1), 1);
    ep0_zlp = 1'b0;
    d0 = done_cnt[0];
    r0 = retry_cnt[0];
    usb_rst = 1'b1;
    repeat (2) tick();
    usb_rst = 1'b0;
    repeat (2) tick();
    check("t5_rst_no_pulse", 32'((done_cnt[0] - d0) + (retry_cnt[0] - r0)), 0);
    load_src(0, 1, 8'h5A);
    w0 = wr_cnt;
    token(EP_CTRL);
    wait_tx("t5b_tx");
    check("t5b_byte", 32'(wr_log[w0]), 32'h5A);
    check("t5b_pid_after_rst", 32'(tx_d1), 0);
    hs_in(1'b1, 1'b0);

    // ACK and timeout together: ACK wins
    load_src(1, 2, 8'hA0);
    token(EP_IN1);
    wait_tx("t6_tx");
    check("t6_pid", 32'(tx_d1), 0);
    d0 = done_cnt[1];
    r0 = retry_cnt[1];
    hs_in(1'b1, 1'b1);
    check("t6_done", 32'(done_cnt[1] - d0), 1);
    check("t6_no_retry", 32'(retry_cnt[1] - r0), 0);
    load_src(1, 1, 8'hB0);
    token(EP_IN1);
    wait_tx("t6b_tx");
    check("t6b_pid", 32'(tx_d1), 1);
    hs_in(1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
